bullet_engine: RTL

BULLET_ENGINE -- requirements
Module: bullet_engine

---
 rtl/bullet_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bullet_engine.sv
// Single-bullet projectile engine: launches on fire, steps one cell every MOVE_DIV
// cycles, and reports the first wall cell it runs into.
module bullet_engine #(
  parameter int MOVE_DIV  = 4,
  parameter int MAX_RANGE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_top_state,
  input  logic [64*44-1:0] i_map,
  input  logic             i_fire,
  input  logic [5:0]       i_x,
  input  logic [5:0]       i_y,
  input  logic [1:0]       i_dir,
  output logic [5:0]       o_hit_x,
  output logic [5:0]       o_hit_y,
  output logic             o_hit_valid,
  output logic [5:0]       o_bullet_x,
  output logic [5:0]       o_bullet_y,
  output logic             o_bullet_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_HIT} state_e;

  localparam logic [7:0] CNT_LAST  = 8'(MOVE_DIV - 1);
  localparam logic [5:0] RANGE_END = 6'(MAX_RANGE);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  range_q, range_d;
  logic [5:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [1:0]  dir_q, dir_d;
  logic [5:0]  hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic        hit_valid_q, hit_valid_d;
  logic        bullet_valid_q, bullet_valid_d;

  logic        playing;
  logic [6:0]  dx, dy, nx, ny;
  logic        in_bounds;
  logic [11:0] map_idx;
  logic        wall;

  always_comb begin
    playing = (i_top_state == 2'b01);
    dx = 7'd0;
    dy = 7'd0;
    case (dir_q)
      2'd0:    dy = 7'h7f;
      2'd1:    dx = 7'd1;
      2'd2:    dy = 7'd1;
      default: dx = 7'h7f;
    endcase
    // 7-bit wrap makes both -1 and 64 land above the upper bound
    nx = {1'b0, pos_x_q} + dx;
    ny = {1'b0, pos_y_q} + dy;
    in_bounds = (nx <= 7'd63) && (ny <= 7'd43);
    map_idx = {ny[5:0], 6'd0} + {6'd0, 6'd63 - nx[5:0]};
    wall = in_bounds && i_map[map_idx];

    state_d = state_q;
    cnt_d   = cnt_q;
    range_d = range_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    hit_x_d = hit_x_q;
    hit_y_d = hit_y_q;

    case (state_q)
      S_IDLE: begin
        if (i_fire && playing) begin
          state_d = S_FLY;
          pos_x_d = i_x;
          pos_y_d = i_y;
          dir_d   = i_dir;
          cnt_d   = 8'd0;
          range_d = 6'd0;
        end
      end
      S_FLY: begin
        if (!playing) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = 8'd0;
          if (!in_bounds) begin
            state_d = S_IDLE;
          end else if (wall) begin
            state_d = S_HIT;
            hit_x_d = nx[5:0];
            hit_y_d = ny[5:0];
          end else begin
            pos_x_d = nx[5:0];
            pos_y_d = ny[5:0];
            range_d = range_q + 6'd1;
            if (range_d == RANGE_END) state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    hit_valid_d    = (state_d == S_HIT);
    bullet_valid_d = (state_d == S_FLY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      range_q        <= 6'd0;
      pos_x_q        <= 6'd0;
      pos_y_q        <= 6'd0;
      dir_q          <= 2'd0;
      hit_x_q        <= 6'd0;
      hit_y_q        <= 6'd0;
      hit_valid_q    <= 1'b0;
      bullet_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      range_q        <= range_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      dir_q          <= dir_d;
      hit_x_q        <= hit_x_d;
      hit_y_q        <= hit_y_d;
      hit_valid_q    <= hit_valid_d;
      bullet_valid_q <= bullet_valid_d;
    end
  end

  assign o_hit_x        = hit_x_q;
  assign o_hit_y        = hit_y_q;
  assign o_hit_valid    = hit_valid_q;
  assign o_bullet_x     = pos_x_q;
  assign o_bullet_y     = pos_y_q;
  assign o_bullet_valid = bullet_valid_q;

endmodule
